lsu_seq: RTL and testbench

Byte-serial load/store sequencer between the CPU's execute/memory stage and the byte-wide data memory. It accepts one load or store request (byte, halfword or word; signed or unsigned loads) over a valid/ready handshake and checks alignment. It then moves the data one byte per cycle through the memory's single byte port, in little-endian order. Finally it returns an extended load result, or a store completion, as a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_seq_load_ext.sv | 21 ++
 rtl/lsu_seq.sv | 113 +++++++++++
 tb/tb_lsu_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the byte-serial load/store sequencer: size encodings,
// sequencer states and the per-size last byte index.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [1:0] last_idx(input size_e sz);
        case (sz)
            SZ_HALF: last_idx = 2'd1;
            SZ_WORD: last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_seq_load_ext.sv
// Combinational load extender: sign- or zero-extends the assembled value
// from bit 7, 15 or 31 according to the access size.
module load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] val,
    input  size_e       size,
    input  logic        sgn,
    output logic [31:0] res
);

    always_comb begin
        res = val;
        case (size)
            SZ_BYTE: res = {{24{sgn & val[7]}},  val[7:0]};
            SZ_HALF: res = {{16{sgn & val[15]}}, val[15:0]};
            default: res = val;
        endcase
    end

endmodule

// File: rtl/lsu_seq.sv
// Byte-serial load/store sequencer: accepts one request, moves one byte per
// cycle through the memory byte port (little-endian), then pulses a response.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e              state, state_nx;
    logic                write_q;
    size_e               size_q;
    logic                signed_q;
    logic [ADDR_W-1:0]   base_q;
    logic [31:0]         wdata_q;
    logic [1:0]          idx_q;
    logic [1:0]          last_q;
    logic [31:0]         asm_q;
    logic                err_q;
    logic [31:0]         ext_val;
    logic                misaligned;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_valid) state_nx = misaligned ? RESP : XFER;
            XFER: if (idx_q == last_q) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            base_q   <= '0;
            wdata_q  <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            asm_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    write_q  <= req_write;
                    size_q   <= size_e'(req_size);
                    signed_q <= req_signed;
                    base_q   <= req_addr[ADDR_W-1:0];
                    wdata_q  <= req_wdata;
                    idx_q    <= '0;
                    last_q   <= last_idx(size_e'(req_size));
                    asm_q    <= '0;
                    err_q    <= misaligned;
                end
                XFER: begin
                    if (!write_q) asm_q[{idx_q, 3'b000} +: 8] <= mem_rdata;
                    // idx stops at the last byte so mem_addr/mem_wdata hold afterwards
                    if (idx_q != last_q) idx_q <= idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    load_ext u_load_ext (
        .val  (asm_q),
        .size (size_q),
        .sgn  (signed_q),
        .res  (ext_val)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = ((state == RESP) && !err_q && !write_q) ? ext_val : '0;
    assign mem_we     = (state == XFER) && write_q;
    assign mem_addr   = base_q + ADDR_W'(idx_q);
    assign mem_wdata  = wdata_q[{idx_q, 3'b000} +: 8];

endmodule

// File: tb/tb_lsu_seq.sv
// Directed self-checking bench for lsu_seq with a behavioural byte memory.
module tb_lsu_seq;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_signed = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0]       r_data;
    logic              r_err;
    int                r_lat;
    int                r_we;
    logic [ADDR_W-1:0] r_addr0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    lsu_seq #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request and waits (bounded) for its response; records latency
    // in cycles after acceptance, store-strobe cycles and first XFER address.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd);
        bit got = 0;
        bit ready_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ready_seen = 1; break; end
        end
        if (!ready_seen) check("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_signed = sg; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~wr; req_size = 2'd3;
        req_signed = ~sg; req_addr = ~addr; req_wdata = ~wd;
        r_we = 0; r_lat = 0; r_data = 'x; r_err = 'x; r_addr0 = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                r_lat = c; r_data = resp_rdata; r_err = resp_err; got = 1;
                break;
            end
            if (mem_we) r_we++;
            if (c == 1) r_addr0 = mem_addr;
            @(posedge clk);
        end
        if (!got) check("resp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #12;
        check("rst_ready",  {31'd0, req_ready},  32'd1);
        check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata",  resp_rdata,          32'd0);
        check("rst_err",    {31'd0, resp_err},   32'd0);
        check("rst_we",     {31'd0, mem_we},     32'd0);
        check("rst_maddr",  32'(mem_addr),       32'd0);
        check("rst_wdata",  32'(mem_wdata),      32'd0);
        // a request held during reset must be ignored
        req_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_ign_we", {31'd0, mem_we}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        check("rst_ign_rv", {31'd0, resp_valid}, 32'd0);

        // byte store, signed and unsigned byte loads
        do_req(1'b1, 2'd0, 1'b0, 32'h004, 32'h0000_00A5);
        check("sb_lat",  r_lat, 32'd2);
        check("sb_we",   r_we, 32'd1);
        check("sb_rd",   r_data, 32'd0);
        check("sb_mem",  32'(mem[4]), 32'hA5);
        do_req(1'b0, 2'd0, 1'b1, 32'h004, 32'd0);
        check("lbs_rd",  r_data, 32'hFFFF_FFA5);
        check("lbs_err", {31'd0, r_err}, 32'd0);
        check("lbs_lat", r_lat, 32'd2);
        do_req(1'b0, 2'd0, 1'b0, 32'h004, 32'd0);
        check("lbu_rd",  r_data, 32'h0000_00A5);

        // word store / load
        do_req(1'b1, 2'd2, 1'b0, 32'h010, 32'h1234_5678);
        check("sw_we",   r_we, 32'd4);
        check("sw_lat",  r_lat, 32'd5);
        check("sw_m0",   32'(mem[16]), 32'h78);
        check("sw_m1",   32'(mem[17]), 32'h56);
        check("sw_m2",   32'(mem[18]), 32'h34);
        check("sw_m3",   32'(mem[19]), 32'h12);
        do_req(1'b0, 2'd2, 1'b0, 32'h010, 32'd0);
        check("lw_rd",   r_data, 32'h1234_5678);
        check("lw_lat",  r_lat, 32'd5);

        // halfword loads
        do_req(1'b0, 2'd1, 1'b1, 32'h012, 32'd0);
        check("lhs_pos", r_data, 32'h0000_1234);
        check("lh_lat",  r_lat, 32'd3);
        do_req(1'b1, 2'd1, 1'b0, 32'h030, 32'h0000_8001);
        check("sh_we",   r_we, 32'd2);
        do_req(1'b0, 2'd1, 1'b1, 32'h030, 32'd0);
        check("lhs_neg", r_data, 32'hFFFF_8001);
        do_req(1'b0, 2'd1, 1'b0, 32'h030, 32'd0);
        check("lhu",     r_data, 32'h0000_8001);

        // error cases
        do_req(1'b0, 2'd1, 1'b0, 32'h003, 32'd0);
        check("e_half_err", {31'd0, r_err}, 32'd1);
        check("e_half_lat", r_lat, 32'd1);
        check("e_half_rd",  r_data, 32'd0);
        do_req(1'b1, 2'd2, 1'b0, 32'h006, 32'hFFFF_FFFF);
        check("e_word_err", {31'd0, r_err}, 32'd1);
        check("e_word_we",  r_we, 32'd0);
        check("e_word_m6",  32'(mem[6]), 32'(mem[6]) & 32'hFF);
        do_req(1'b0, 2'd3, 1'b0, 32'h000, 32'd0);
        check("e_rsvd_err", {31'd0, r_err}, 32'd1);
        check("e_rsvd_rd",  r_data, 32'd0);
        check("e_rsvd_lat", r_lat, 32'd1);

        // address truncation and top-of-memory word
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0400, 32'd0);
        check("trunc_addr", 32'(r_addr0), 32'h000);
        do_req(1'b1, 2'd2, 1'b0, 32'h3FC, 32'h4433_2211);
        check("top_m3ff",   32'(mem[10'h3FF]), 32'h44);
        do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0);
        check("top_addr0",  32'(r_addr0), 32'h3FC);
        check("top_rd",     r_data, 32'h4433_2211);

        // reset during the second byte of a word store
        do_req(1'b1, 2'd2, 1'b0, 32'h020, 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
        req_addr = 32'h020; req_wdata = 32'hCAFE_BABE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("abrt_we_pre", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abrt_we",    {31'd0, mem_we},     32'd0);
        check("abrt_ready", {31'd0, req_ready},  32'd1);
        check("abrt_rv",    {31'd0, resp_valid}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        begin
            int rv = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (resp_valid) rv++;
            end
            check("abrt_no_resp", rv, 32'd0);
        end
        check("abrt_ready2", {31'd0, req_ready}, 32'd1);
        check("abrt_m0", 32'(mem[32]), 32'hBE);
        check("abrt_m1", 32'(mem[33]), 32'h00);
        check("abrt_m2", 32'(mem[34]), 32'h00);
        check("abrt_m3", 32'(mem[35]), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
